conv_acc_quant: RTL and testbench

- Downstream neighbour of the Conv datapath's 16x16 unsigned multiplier.
- Consumes its 32-bit unsigned product stream and accumulates one convolution window of cfg_len products, seeded with a signed bias.
- Applies ReLU, rounding right-shift requantisation and 16-bit unsigned saturation.
- Emits one output pixel per window on a valid/ready stream toward the feature-map writer.

---
 rtl/conv_acc_quant_pkg.sv | 29 ++
 rtl/conv_acc_quant_if.sv | 47 ++++
 rtl/conv_acc_quant_requant.sv | 48 ++++
 rtl/conv_acc_quant.sv | 135 +++++++++++++
 tb/tb_conv_acc_quant.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_acc_quant_pkg.sv
// Shared constants and helpers for the convolution accumulate/requantise path.
// Holds datapath widths, the window-controller state encoding and the
// window-length clamp used when a new window starts.
package conv_acc_quant_pkg;

  localparam int PROD_W  = 32;  // unsigned product from the 16x16 multiplier
  localparam int BIAS_W  = 32;  // two's complement bias
  localparam int OUT_W   = 16;  // unsigned output pixel
  localparam int MAX_LEN = 256; // largest window in products
  localparam int LEN_W   = 9;   // holds 0..MAX_LEN
  localparam int ACC_W   = 42;  // PROD_W + clog2(MAX_LEN) + 2 guard/sign bits
  localparam int SHIFT_W = 5;   // requantisation right-shift amount

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Effective window length: 0 behaves as a single product, anything above
  // MAX_LEN is limited to MAX_LEN.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len == '0) return LEN_W'(1);
    if (len > LEN_W'(MAX_LEN)) return LEN_W'(MAX_LEN);
    return len;
  endfunction

endpackage

// File: rtl/conv_acc_quant_if.sv
// Stream bundle between the multiplier, conv_acc_quant and the feature-map
// writer.
//   cfg_len/cfg_shift/cfg_bias : per-window configuration (sampled on the
//                                first beat of a window)
//   in_data/in_valid/in_ready  : product stream into the block
//   out_data/out_sat/out_clip/out_valid/out_ready : pixel stream out
//   busy                       : window in progress or pixel pending
// slave  : the accumulate/requantise block
// master : its environment (product source and pixel sink)
interface conv_acc_quant_if;
  import conv_acc_quant_pkg::*;

  logic        [LEN_W-1:0]   cfg_len;
  logic        [SHIFT_W-1:0] cfg_shift;
  logic signed [BIAS_W-1:0]  cfg_bias;

  logic [PROD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  logic [OUT_W-1:0]  out_data;
  logic              out_sat;
  logic              out_clip;
  logic              out_valid;
  logic              out_ready;

  logic              busy;

  modport slave (
    input  cfg_len, cfg_shift, cfg_bias,
    input  in_data, in_valid,
    output in_ready,
    output out_data, out_sat, out_clip, out_valid,
    input  out_ready,
    output busy
  );

  modport master (
    output cfg_len, cfg_shift, cfg_bias,
    output in_data, in_valid,
    input  in_ready,
    input  out_data, out_sat, out_clip, out_valid,
    output out_ready,
    input  busy
  );

endinterface

// File: rtl/conv_acc_quant_requant.sv
// Combinational requantiser: ReLU, round-half-up arithmetic right shift and
// unsigned saturation to OUT_W bits. Shared with the depthwise path.
//   acc_i   : signed accumulator value
//   shift_i : right-shift amount
//   data_o  : quantised pixel
//   sat_o   : result exceeded the OUT_W range and was forced to all ones
//   clip_o  : accumulator was negative and ReLU forced zero
module conv_acc_quant_requant
  import conv_acc_quant_pkg::*;
(
  input  logic signed [ACC_W-1:0]   acc_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  output logic        [OUT_W-1:0]   data_o,
  output logic                      sat_o,
  output logic                      clip_o
);

  // Only reached for non-negative values, so the operand is treated as
  // unsigned. The largest sum plus half an LSB still fits in ACC_W bits.
  function automatic logic [ACC_W-1:0] round_shift(input logic [ACC_W-1:0]   v,
                                                   input logic [SHIFT_W-1:0] sh);
    logic [ACC_W-1:0] half;
    half = (sh == '0) ? '0 : (ACC_W'(1) << (sh - SHIFT_W'(1)));
    return (v + half) >> sh;
  endfunction

  // Returns {sat, data}.
  function automatic logic [OUT_W:0] sat_u(input logic [ACC_W-1:0] r);
    if (|r[ACC_W-1:OUT_W]) return {1'b1, {OUT_W{1'b1}}};
    return {1'b0, r[OUT_W-1:0]};
  endfunction

  logic [ACC_W-1:0] rounded;

  always_comb begin
    rounded = '0;
    data_o  = '0;
    sat_o   = 1'b0;
    clip_o  = 1'b0;
    if (acc_i[ACC_W-1]) begin
      clip_o = 1'b1;
    end else begin
      rounded         = round_shift($unsigned(acc_i), shift_i);
      {sat_o, data_o} = sat_u(rounded);
    end
  end

endmodule

// File: rtl/conv_acc_quant.sv
// Accumulates one convolution window of unsigned products on top of a signed
// bias, then requantises the sum into one unsigned pixel held in a registered
// output slot until the writer takes it.
//   ap_clk   : clock, rising edge
//   ap_rst_n : asynchronous active-low reset
//   s        : stream bundle (configuration, product input, pixel output, busy)
module conv_acc_quant
  import conv_acc_quant_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  conv_acc_quant_if.slave   s
);

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [LEN_W-1:0]   count_q, count_d;
  logic        [LEN_W-1:0]   len_q, len_d;
  logic        [SHIFT_W-1:0] shift_q, shift_d;
  logic        [OUT_W-1:0]   out_data_q, out_data_d;
  logic                      out_sat_q, out_sat_d;
  logic                      out_clip_q, out_clip_d;
  logic                      out_valid_q, out_valid_d;
  // Set one clock after reset release so in_ready rises synchronously.
  logic                      run_q, run_d;

  logic                      in_ready;
  logic                      accept;
  logic                      start;
  logic        [LEN_W-1:0]   new_len;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic        [OUT_W-1:0]   rq_data;
  logic                      rq_sat;
  logic                      rq_clip;

  conv_acc_quant_requant u_requant (
    .acc_i   (acc_q),
    .shift_i (shift_q),
    .data_o  (rq_data),
    .sat_o   (rq_sat),
    .clip_o  (rq_clip)
  );

  // In HOLD a new window may only start while the pending pixel leaves.
  assign in_ready = run_q &&
                    ((state_q == IDLE) || (state_q == ACC) ||
                     ((state_q == HOLD) && s.out_ready));
  assign accept   = s.in_valid && in_ready;
  assign start    = accept && ((state_q == IDLE) || (state_q == HOLD));
  assign new_len  = clamp_len(s.cfg_len);
  assign prod_ext = signed'({{(ACC_W-PROD_W){1'b0}}, s.in_data});
  assign bias_ext = signed'({{(ACC_W-BIAS_W){s.cfg_bias[BIAS_W-1]}}, s.cfg_bias});

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    len_d       = len_q;
    shift_d     = shift_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_clip_d  = out_clip_q;
    out_valid_d = out_valid_q;
    run_d       = 1'b1;

    case (state_q)
      IDLE: ;
      ACC: begin
        if (accept) begin
          acc_d   = acc_q + prod_ext;
          count_d = count_q + LEN_W'(1);
          if ((count_q + LEN_W'(1)) == len_q) state_d = FIN;
        end
      end
      FIN: begin
        out_data_d  = rq_data;
        out_sat_d   = rq_sat;
        out_clip_d  = rq_clip;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (s.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // First beat of a window, from IDLE or overlapping the HOLD hand-off.
    if (start) begin
      len_d   = new_len;
      shift_d = s.cfg_shift;
      acc_d   = bias_ext + prod_ext;
      count_d = LEN_W'(1);
      state_d = (new_len == LEN_W'(1)) ? FIN : ACC;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      len_q       <= LEN_W'(1);
      shift_q     <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_clip_q  <= 1'b0;
      out_valid_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_clip_q  <= out_clip_d;
      out_valid_q <= out_valid_d;
      run_q       <= run_d;
    end
  end

  assign s.in_ready  = in_ready;
  assign s.out_data  = out_data_q;
  assign s.out_sat   = out_sat_q;
  assign s.out_clip  = out_clip_q;
  assign s.out_valid = out_valid_q;
  assign s.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_acc_quant.sv
// Bench for conv_acc_quant: directed windows for the arithmetic boundaries,
// backpressure and reset, then randomized windows with random gaps, random
// out_ready and mid-window configuration noise, all scored against a plain
// arithmetic model of window sum, ReLU, rounding and saturation.
module tb_conv_acc_quant;

  logic ap_clk;
  logic ap_rst_n;

  conv_acc_quant_if ifc ();

  conv_acc_quant dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .s        (ifc)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  longint      prod_buf [0:511];
  logic [17:0] exp_q [$];          // {clip, sat, data}
  bit          rdy_rand   = 0;
  bit          arm_stall  = 0;
  int          stall_left = 0;
  bit          stall_prev = 0;
  logic [17:0] held;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Window result from the arithmetic definition.
  function automatic logic [17:0] model(input int n, input int bias, input int sh);
    longint sum;
    longint r;
    logic [15:0] d;
    sum = longint'(bias);
    for (int i = 0; i < n; i++) sum += prod_buf[i];
    if (sum < 0) return {1'b1, 1'b0, 16'h0000};
    r = sum + ((sh != 0) ? (longint'(1) << (sh - 1)) : 0);
    r = r >>> sh;
    if (r > 65535) return {1'b0, 1'b1, 16'hFFFF};
    d = r[15:0];
    return {1'b0, 1'b0, d};
  endfunction

  function automatic int eff_len(input int cl);
    if (cl == 0) return 1;
    if (cl > 256) return 256;
    return cl;
  endfunction

  // Pixel sink: out_ready policy, applied just after each rising edge.
  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge ap_clk);
      #1;
      if (arm_stall && ifc.out_valid) begin
        stall_left = 5;
        arm_stall  = 0;
      end
      if (stall_left > 0) begin
        ifc.out_ready = 1'b0;
        stall_left--;
      end else if (rdy_rand) begin
        ifc.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        ifc.out_ready = 1'b1;
      end
    end
  end

  // Output scoreboard and stall behaviour, sampled on the falling edge.
  always @(negedge ap_clk) begin
    logic [17:0] e;
    if (!ap_rst_n) begin
      stall_prev = 0;
    end else begin
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", ifc.out_data, e[15:0]);
          check("out_sat", ifc.out_sat, e[16]);
          check("out_clip", ifc.out_clip, e[17]);
        end
      end
      if (ifc.out_valid && !ifc.out_ready) begin
        check("stall_in_ready", ifc.in_ready, 0);
        if (stall_prev) check("stall_hold", {ifc.out_clip, ifc.out_sat, ifc.out_data}, held);
        held       = {ifc.out_clip, ifc.out_sat, ifc.out_data};
        stall_prev = 1;
      end else begin
        stall_prev = 0;
      end
    end
  end

  // Present one beat and return just after the edge that accepted it.
  task automatic drive_beat(input logic [31:0] d, input int cl, input int sh,
                            input int bias, input bit first);
    int t;
    bit done;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    if (first) begin
      ifc.cfg_len   = 9'(cl);
      ifc.cfg_shift = 5'(sh);
      ifc.cfg_bias  = bias;
    end else begin
      ifc.cfg_len   = 9'($urandom);
      ifc.cfg_shift = 5'($urandom);
      ifc.cfg_bias  = $urandom;
    end
    t    = 0;
    done = 0;
    while (!done) begin
      @(negedge ap_clk);
      if (ifc.in_ready) begin
        done = 1;
      end else begin
        t++;
        if (t > 2000) begin
          check("accept_timeout", 0, 1);
          $fatal(1, "no beat accepted");
        end
      end
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send_window(input int cl, input int sh, input int bias,
                             input int nbeats, input bit push, input bit gaps);
    if (push) exp_q.push_back(model(nbeats, bias, sh));
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        ifc.in_valid  = 1'b0;
        ifc.in_data   = $urandom;
        ifc.cfg_len   = 9'($urandom);
        ifc.cfg_shift = 5'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge ap_clk);
        #1;
      end
      drive_beat(prod_buf[i][31:0], cl, sh, bias, (i == 0));
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0) && (t < 3000)) begin
      @(posedge ap_clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge ap_clk);
    #1;
  endtask

  task automatic one_beat(input longint p, input int cl, input int sh);
    prod_buf[0] = p;
    send_window(cl, sh, 0, eff_len(cl), 1, 0);
  endtask

  task automatic two_beats(input longint a, input longint b, input int sh, input int bias);
    prod_buf[0] = a;
    prod_buf[1] = b;
    send_window(2, sh, bias, 2, 1, 0);
  endtask

  initial begin
    int cl, sh, bias, cat, nb;
    ap_rst_n      = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.cfg_len   = '0;
    ifc.cfg_shift = '0;
    ifc.cfg_bias  = '0;

    // Reset state.
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_in_ready", ifc.in_ready, 0);
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_out_data", ifc.out_data, 0);
    check("rst_out_sat", ifc.out_sat, 0);
    check("rst_out_clip", ifc.out_clip, 0);
    check("rst_busy", ifc.busy, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    check("in_ready_after_rst", ifc.in_ready, 1);

    // Basic sum and two-cycle latency.
    prod_buf[0] = 10; prod_buf[1] = 20; prod_buf[2] = 30;
    send_window(3, 0, 0, 3, 1, 0);
    @(negedge ap_clk);
    check("lat_fin", ifc.out_valid, 0);
    check("busy_fin", ifc.busy, 1);
    @(negedge ap_clk);
    check("lat_hold", ifc.out_valid, 1);
    wait_drain();

    // ReLU clip versus exact zero.
    two_beats(30, 40, 0, -100);
    two_beats(30, 40, 0, -70);
    // Saturation and rounding boundaries around 2^32 >> 16.
    two_beats(64'hFFFF0000, 64'h00010000, 0, 0);
    two_beats(64'hFFFF0000, 64'h00010000, 16, 0);
    two_beats(64'hFFFF0000, 64'h0000FFFF, 16, 0);
    two_beats(64'hFFFF0000, 64'h00007FFF, 16, 0);
    two_beats(64'hFFFF0000, 64'h00008000, 16, 0);
    // Round half up on single-product windows; zero length behaves as one.
    one_beat(6, 1, 2);
    one_beat(5, 1, 2);
    one_beat(4, 1, 2);
    one_beat(7, 0, 0);
    wait_drain();

    // Backpressure during the first HOLD with three back-to-back windows.
    arm_stall = 1;
    two_beats(100, 200, 0, 5);
    two_beats(1000, 3, 1, -1);
    two_beats(70000, 1, 2, 0);
    wait_drain();

    // Reset in the middle of a window discards it.
    prod_buf[0] = 9; prod_buf[1] = 9;
    send_window(4, 0, 0, 2, 0, 0);
    ap_rst_n = 1'b0;
    #1;
    check("midrst_out_valid", ifc.out_valid, 0);
    check("midrst_busy", ifc.busy, 0);
    check("midrst_in_ready", ifc.in_ready, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    check("midrst_in_ready_after", ifc.in_ready, 1);
    two_beats(1, 2, 0, 0);
    wait_drain();

    // Randomized windows with random gaps and random out_ready.
    rdy_rand = 1;
    for (int w = 0; w < 40; w++) begin
      cl  = ($urandom_range(0, 9) == 0) ? $urandom_range(257, 511) : $urandom_range(0, 6);
      nb  = eff_len(cl);
      sh  = $urandom_range(0, 31);
      cat = $urandom_range(0, 2);
      bias = (cat == 0) ? (int'($urandom_range(0, 4000)) - 2000) : int'($urandom);
      for (int i = 0; i < nb; i++) begin
        if (cat == 0)      prod_buf[i] = $urandom_range(0, 1000);
        else if (cat == 1) prod_buf[i] = $urandom_range(0, 1 << 20);
        else               prod_buf[i] = longint'($urandom);
      end
      send_window(cl, sh, bias, nb, 1, 1);
    end
    rdy_rand = 0;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
